usb_rst_sequencer: RTL and testbench
====================================

Name: usb_rst_sequencer

Overview:
- Avalon-MM slave that sequences the USB host controller's hardware reset pin.
- Replaces direct software toggling of the USB reset PIO with a timed sequence: assert reset, hold, release, settle.
- Gates host-port-interface (HPI) traffic until the chip is ready.
- Sits beside the USB HPI PIOs; the CPU driver issues one start command, then polls STATUS or takes an interrupt.

Parameters:
- CNT_W, 16, width of the assert and settle counters and their registers.
- DEF_ASSERT, 16'd5000, reset value of ASSERT_CYCLES (clk cycles usb_rst_n is held low).
- DEF_SETTLE, 16'd10000, reset value of SETTLE_CYCLES (clk cycles after release before ready).
- AUTO_START, 1, 1 = run one sequence automatically after reset_n deasserts.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address.
- usb_rst_n  out  1  to USB chip reset pin, active-low, registered.
- hpi_block  out  1  1 = HPI bridge must stall or refuse accesses.
- irq  out  1  completion interrupt (only with optional feature; otherwise tied 0).

Behaviour:
Register map (word addresses):
- 0 CTRL: write bit0 = START (self-clearing pulse), bit1 = HOLD (level), bit2 = IRQ_EN (feature only). Reads return {29'b0, IRQ_EN, HOLD, 1'b0}.
- 1 STATUS: bit0 = BUSY, bit1 = DONE (sticky), bit2 = READY. Any write clears DONE.
- 2 ASSERT_CYCLES: CNT_W bits, zero-extended on read.
- 3 SETTLE_CYCLES: CNT_W bits, zero-extended on read.
- A write decodes as chipselect & ~write_n.

FSM states: IDLE, ASSERT, SETTLE, READY.
- Reset (async): goes to ASSERT if AUTO_START=1, else IDLE. Outputs at reset: usb_rst_n=0, hpi_block=1, DONE=0, HOLD=0, IRQ_EN=0, counter=0. Count registers take their DEF_ values.
- IDLE: usb_rst_n=1, hpi_block=1. START -> ASSERT on the next edge with counter=0.
- ASSERT: usb_rst_n=0, hpi_block=1, counter increments each cycle. Leave when counter >= max(ASSERT_CYCLES,1)-1 and HOLD=0; then go to SETTLE with counter cleared. Low time is therefore exactly max(ASSERT_CYCLES,1) cycles.
- SETTLE: usb_rst_n=1, hpi_block=1. After max(SETTLE_CYCLES,1) cycles -> READY, DONE<=1.
- READY: usb_rst_n=1, hpi_block=0, READY=1. START -> ASSERT.
- BUSY = state is ASSERT or SETTLE.
- HOLD=1 in any state forces ASSERT (counter cleared, usb_rst_n=0 on the next edge). While HOLD=1 the FSM stays in ASSERT. On HOLD 1->0 a full ASSERT count runs, then SETTLE.
- START while BUSY is ignored; the counter does not restart.
- START together with HOLD in one write: HOLD wins, START is discarded.
- Writes to ASSERT_CYCLES/SETTLE_CYCLES during BUSY take effect immediately; the comparison uses the live register value.
- DONE set and a STATUS write on the same cycle: set wins.
- Counter saturates; it never wraps.
- reset_n asserted mid-sequence: immediate return to reset state as above.

Optional Feature:
- Macro: USB_RST_SEQ_IRQ_EN.
- Defined: IRQ_EN bit implemented; irq = DONE & IRQ_EN, registered, level, cleared via the DONE-clear write.
- Undefined: IRQ_EN bit reads 0, writes are ignored, irq constant 0.

Test Plan:
- AUTO_START=1, DEF_ASSERT=4, DEF_SETTLE=3, release reset_n -> usb_rst_n low 4 cycles, then hpi_block=1 for 3 cycles, then READY=1, DONE=1, hpi_block=0; STATUS reads 0x6.
- AUTO_START=0, write ASSERT=0, SETTLE=0, START -> usb_rst_n low exactly 1 cycle, settle 1 cycle, STATUS=0x6.
- During SETTLE, write START -> ignored, DONE timing unchanged. After READY, write STATUS -> reads 0x4.
- From READY, write CTRL=0x2 for 20 cycles -> usb_rst_n low throughout, BUSY=1. Then write CTRL=0 -> ASSERT_CYCLES more low cycles, then settle.
- Feature defined: CTRL=0x5 (IRQ_EN+START), ASSERT=2, SETTLE=2 -> irq rises the cycle after DONE; STATUS write -> irq falls. Feature undefined: irq stays 0.
- Assert reset_n mid-ASSERT -> usb_rst_n=0, DONE=0, counters reset; the sequence restarts from the DEF_ values.

Source files
------------

// File: rtl/usb_rst_sequencer.sv
// Avalon-MM sequencer for the USB host chip reset pin: assert, hold, release, settle, then ungate HPI traffic.
// Optional completion interrupt enabled by defining USB_RST_SEQ_IRQ_EN.
module usb_rst_sequencer #(
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] DEF_ASSERT = 16'd5000,
  parameter logic [CNT_W-1:0] DEF_SETTLE = 16'd10000,
  parameter bit               AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        usb_rst_n,
  output logic        hpi_block,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SETTLE, S_READY} state_t;
  localparam state_t RST_STATE = AUTO_START ? S_ASSERT : S_IDLE;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] assert_cycles, settle_cycles, thr_assert, thr_settle;
  logic             hold, done, done_set, irq_en;
  logic             wr, wr_ctrl, wr_stat, start, busy, ready;
  logic             unused;

  assign wr      = chipselect & ~write_n;
  assign wr_ctrl = wr & (address == 2'd0);
  assign wr_stat = wr & (address == 2'd1);
  // HOLD in the same write discards START.
  assign start   = wr_ctrl & writedata[0] & ~writedata[1];
  assign busy    = (state == S_ASSERT) | (state == S_SETTLE);
  assign ready   = (state == S_READY);
  assign unused  = ^writedata;

  // Thresholds are max(N,1)-1 so a zero count still gives one cycle.
  assign thr_assert = (assert_cycles == '0) ? '0 : assert_cycles - ONE;
  assign thr_settle = (settle_cycles == '0) ? '0 : settle_cycles - ONE;
  assign cnt_inc    = (cnt == '1) ? cnt : cnt + ONE;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_set  = 1'b0;
    if (hold) begin
      state_nxt = S_ASSERT;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE, S_READY: begin
          if (start) begin
            state_nxt = S_ASSERT;
            cnt_nxt   = '0;
          end
        end
        S_ASSERT: begin
          if (cnt >= thr_assert) begin
            state_nxt = S_SETTLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        S_SETTLE: begin
          if (cnt >= thr_settle) begin
            state_nxt = S_READY;
            cnt_nxt   = '0;
            done_set  = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RST_STATE;
      cnt           <= '0;
      hold          <= 1'b0;
      done          <= 1'b0;
      usb_rst_n     <= 1'b0;
      assert_cycles <= DEF_ASSERT;
      settle_cycles <= DEF_SETTLE;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      usb_rst_n <= (state_nxt != S_ASSERT);
      if (wr_ctrl) hold <= writedata[1];
      // A completion on the same cycle as a STATUS write keeps DONE set.
      if (done_set)     done <= 1'b1;
      else if (wr_stat) done <= 1'b0;
      if (wr & (address == 2'd2)) assert_cycles <= writedata[CNT_W-1:0];
      if (wr & (address == 2'd3)) settle_cycles <= writedata[CNT_W-1:0];
    end
  end

`ifdef USB_RST_SEQ_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= writedata[2];
      irq <= done & irq_en;
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  assign hpi_block = ~ready;

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {29'd0, irq_en, hold, 1'b0};
      2'd1:    readdata = {29'd0, ready, done, busy};
      2'd2:    readdata = 32'(assert_cycles);
      default: readdata = 32'(settle_cycles);
    endcase
  end

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Bench for usb_rst_sequencer: instance 0 auto-starts, instance 1 waits in IDLE; both checked every cycle against a phase/elapsed-time model.
module tb_usb_rst_sequencer;

`ifdef USB_RST_SEQ_IRQ_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic [1:0]  cs;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rdata [2];
  logic [1:0]  urst, hpi, irqs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  usb_rst_sequencer #(.CNT_W(16), .DEF_ASSERT(16'd4), .DEF_SETTLE(16'd3), .AUTO_START(1'b1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]), .write_n(write_n),
    .writedata(writedata), .readdata(rdata[0]), .usb_rst_n(urst[0]), .hpi_block(hpi[0]), .irq(irqs[0]));

  usb_rst_sequencer #(.CNT_W(16), .DEF_ASSERT(16'd4), .DEF_SETTLE(16'd3), .AUTO_START(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]), .write_n(write_n),
    .writedata(writedata), .readdata(rdata[1]), .usb_rst_n(urst[1]), .hpi_block(hpi[1]), .irq(irqs[1]));

  // Reference: a phase plus the number of cycles already spent in it.
  typedef enum {P_OFF, P_LOW, P_WAIT, P_ON} phase_t;
  phase_t m_ph [2];
  int     m_el [2], m_a [2], m_s [2];
  bit     m_hold [2], m_done [2], m_ien [2], m_irq [2], m_urst [2];

  function automatic int at_least1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic logic [31:0] m_read(input int k, input logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, m_ien[k], m_hold[k], 1'b0};
      2'd1:    return {29'd0, m_ph[k] == P_ON, m_done[k], m_ph[k] == P_LOW || m_ph[k] == P_WAIT};
      2'd2:    return 32'(m_a[k]);
      default: return 32'(m_s[k]);
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    phase_t np;
    int     ne;
    bit     w, start, fin;
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_ph[k] = (k == 0) ? P_LOW : P_OFF;
        m_el[k] = 0; m_a[k] = 4; m_s[k] = 3;
        m_hold[k] = 0; m_done[k] = 0; m_ien[k] = 0; m_irq[k] = 0; m_urst[k] = 0;
      end else begin
        w     = cs[k] && !write_n;
        start = w && address == 2'd0 && writedata[0] && !writedata[1];
        np = m_ph[k]; ne = m_el[k]; fin = 0;
        if (m_hold[k]) begin
          np = P_LOW; ne = 0;
        end else if ((m_ph[k] == P_OFF || m_ph[k] == P_ON) && start) begin
          np = P_LOW; ne = 0;
        end else if (m_ph[k] == P_LOW) begin
          if (m_el[k] + 1 >= at_least1(m_a[k])) begin np = P_WAIT; ne = 0; end
          else ne = (m_el[k] + 1 > 65535) ? 65535 : m_el[k] + 1;
        end else if (m_ph[k] == P_WAIT) begin
          if (m_el[k] + 1 >= at_least1(m_s[k])) begin np = P_ON; ne = 0; fin = 1; end
          else ne = (m_el[k] + 1 > 65535) ? 65535 : m_el[k] + 1;
        end
        m_irq[k]  = FEAT && m_done[k] && m_ien[k];
        m_done[k] = fin || (m_done[k] && !(w && address == 2'd1));
        if (w && address == 2'd0) begin
          m_hold[k] = writedata[1];
          if (FEAT) m_ien[k] = writedata[2];
        end
        if (w && address == 2'd2) m_a[k] = int'(writedata[15:0]);
        if (w && address == 2'd3) m_s[k] = int'(writedata[15:0]);
        m_ph[k] = np; m_el[k] = ne;
        m_urst[k] = (np != P_LOW);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model usb_rst_n[%0d]", k), 32'(urst[k]), 32'(m_urst[k]));
      chk($sformatf("model hpi_block[%0d]", k), 32'(hpi[k]), 32'(m_ph[k] != P_ON));
      chk($sformatf("model irq[%0d]", k), 32'(irqs[k]), 32'(m_irq[k]));
      chk($sformatf("model readdata[%0d] a=%0d", k, address), rdata[k], m_read(k, address));
    end
  end

  task automatic wr(input int k, input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cs[k] = 1'b1; address = a; write_n = 1'b0; writedata = d;
    @(posedge clk); #1;
    cs = 2'b00; write_n = 1'b1;
  endtask

  task automatic rd(input int k, input logic [1:0] a, input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    address = a;
    @(negedge clk); #1;
    chk(nm, rdata[k], exp);
  endtask

  // Counts low cycles of usb_rst_n, then the following cycles with hpi_block still set.
  task automatic measure(input int k, output int lo, output int st);
    int n;
    lo = 0; st = 0; n = 0;
    @(negedge clk);
    while (urst[k] && n < 100) begin @(negedge clk); n++; end
    while (!urst[k] && n < 300) begin lo++; @(negedge clk); n++; end
    while (hpi[k] && n < 500) begin st++; @(negedge clk); n++; end
    if (n >= 100 && lo == 0) chk("measure timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int lo, st, n;
    bit seen;
    logic [31:0] tmp;
    reset_n = 1'b0; cs = 2'b00; write_n = 1'b1; address = 2'd1; writedata = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset usb_rst_n0", 32'(urst[0]), 32'd0);
    chk("reset hpi_block0", 32'(hpi[0]), 32'd1);
    chk("reset status0", rdata[0], 32'h1);
    chk("reset status1", rdata[1], 32'h0);

    // Auto-start after release: 4 low, 3 settle.
    @(posedge clk); #1 reset_n = 1'b1;
    measure(0, lo, st);
    chk("auto low cycles", 32'(lo), 32'd4);
    chk("auto settle cycles", 32'(st), 32'd3);
    rd(0, 2'd1, 32'h6, "auto status");
    rd(1, 2'd1, 32'h0, "idle status");

    // Zero counts still give one cycle each.
    wr(1, 2'd2, 32'd0); wr(1, 2'd3, 32'd0); wr(1, 2'd0, 32'h1);
    measure(1, lo, st);
    chk("zero low cycles", 32'(lo), 32'd1);
    chk("zero settle cycles", 32'(st), 32'd1);
    rd(1, 2'd1, 32'h6, "zero status");

    // START during SETTLE is ignored.
    wr(0, 2'd2, 32'd3); wr(0, 2'd3, 32'd6); wr(0, 2'd0, 32'h1);
    n = 0;
    fork
      begin repeat (5) @(posedge clk); wr(0, 2'd0, 32'h1); end
      begin
        @(negedge clk);
        while (hpi[0] && n < 50) begin n++; @(negedge clk); end
      end
    join
    chk("busy cycles with ignored start", 32'(n), 32'd9);
    rd(0, 2'd1, 32'h6, "status before clear");
    wr(0, 2'd1, 32'h0);
    rd(0, 2'd1, 32'h4, "status after clear");

    // HOLD for 20 cycles, then a full assert count.
    wr(0, 2'd0, 32'h2);
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("held usb_rst_n", 32'(urst[0]), 32'd0);
      chk("held busy", 32'(rdata[0][0] | (address != 2'd1)), 32'd1);
    end
    wr(0, 2'd0, 32'h0);
    measure(0, lo, st);
    chk("post-hold low", 32'(lo), 32'd3);
    chk("post-hold settle", 32'(st), 32'd6);

    // Interrupt enable with start.
    wr(0, 2'd1, 32'h0); wr(0, 2'd2, 32'd2); wr(0, 2'd3, 32'd2); wr(0, 2'd0, 32'h5);
    @(posedge clk); #1 address = 2'd1;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (rdata[0][1]) begin
        seen = 1;
        chk("irq with done", 32'(irqs[0]), 32'd0);
        @(negedge clk);
        chk("irq after done", 32'(irqs[0]), 32'(FEAT));
      end
    end
    chk("done seen", 32'(seen), 32'd1);
    wr(0, 2'd1, 32'h0);
    repeat (2) @(negedge clk);
    chk("irq cleared", 32'(irqs[0]), 32'd0);
    rd(0, 2'd0, FEAT ? 32'h4 : 32'h0, "ctrl readback");

    // Reset mid-ASSERT restarts from defaults.
    wr(0, 2'd2, 32'd50); wr(0, 2'd0, 32'h1);
    address = 2'd1;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("midreset usb_rst_n", 32'(urst[0]), 32'd0);
    chk("midreset status", rdata[0], 32'h1);
    @(posedge clk); #1 reset_n = 1'b1;
    measure(0, lo, st);
    chk("restart low", 32'(lo), 32'd4);
    chk("restart settle", 32'(st), 32'd3);
    rd(0, 2'd2, 32'd4, "assert default");

    for (int it = 0; it < 3000; it++) begin
      int r, k;
      @(posedge clk); #1;
      cs = 2'b00; write_n = 1'b1; reset_n = 1'b1;
      r = $urandom_range(0, 99); k = $urandom_range(0, 1);
      tmp = $urandom;
      address = 2'($urandom_range(0, 3));
      if (r < 6) begin
        cs[k] = 1'b1; write_n = 1'b0; address = 2'd0;
        writedata = {tmp[31:3], tmp[2], $urandom_range(0, 3) == 0, tmp[0]};
      end else if (r < 10) begin
        cs[k] = 1'b1; write_n = 1'b0; address = 2'd1; writedata = tmp;
      end else if (r < 18) begin
        cs[k] = 1'b1; write_n = 1'b0; address = (r < 14) ? 2'd2 : 2'd3;
        writedata = {tmp[31:16], 16'($urandom_range(0, 5))};
      end else if (r < 19) begin
        reset_n = 1'b0;
      end else if (r < 25) begin
        cs[k] = 1'b1; writedata = tmp;
      end
    end
    @(posedge clk); #1;
    cs = 2'b00; write_n = 1'b1; reset_n = 1'b1;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
